// File: rtl/alu_arbiter_pkg.sv
// Shared ALU definitions: datapath width, operation codes and the request bundle
// that the arbiter steers onto the ALU inputs.
package alu_arbiter_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [3:0] ALU_OP_ADD  = 4'h0;
  localparam logic [3:0] ALU_OP_SUB  = 4'h1;
  localparam logic [3:0] ALU_OP_SLL  = 4'h2;
  localparam logic [3:0] ALU_OP_SLT  = 4'h3;
  localparam logic [3:0] ALU_OP_SLTU = 4'h4;
  localparam logic [3:0] ALU_OP_XOR  = 4'h5;
  localparam logic [3:0] ALU_OP_SRL  = 4'h6;
  localparam logic [3:0] ALU_OP_SRA  = 4'h7;
  localparam logic [3:0] ALU_OP_OR   = 4'h8;
  localparam logic [3:0] ALU_OP_AND  = 4'h9;

  typedef struct packed {
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } alu_req_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared 32-bit ALU with a registered result: the value computed from the
// inputs in one cycle appears on out_s in the next. Unknown op codes yield 0.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] out_s
);

  logic [XLEN-1:0] res_s;

  // Combinational result selection by op code.
  always_comb begin
    res_s = {XLEN{1'b0}};
    case (op)
      ALU_OP_ADD:  res_s = a + b;
      ALU_OP_SUB:  res_s = a - b;
      ALU_OP_SLL:  res_s = a << b[4:0];
      ALU_OP_SRL:  res_s = a >> b[4:0];
      ALU_OP_SRA:  res_s = $unsigned($signed(a) >>> b[4:0]);
      ALU_OP_SLT:  res_s = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_OP_SLTU: res_s = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_OP_XOR:  res_s = a ^ b;
      ALU_OP_OR:   res_s = a | b;
      ALU_OP_AND:  res_s = a & b;
      default:     res_s = {XLEN{1'b0}};
    endcase
  end

  // Result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_s <= {XLEN{1'b0}};
    end else begin
      out_s <= res_s;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of the shared registered ALU. Port 0 is the integer
// pipeline, port 1 the address/CSR path. One op issues per cycle; the in-flight
// tag routes the ALU result into the owning port's one-entry response slot.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [3:0]      req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [3:0]      req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic            resp0_valid,
  input  logic            resp0_ready,
  output logic [XLEN-1:0] resp0_data,
  output logic            resp1_valid,
  input  logic            resp1_ready,
  output logic [XLEN-1:0] resp1_data
);

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  logic            inflight_v_r;
  logic            inflight_id_r;
  logic            last_r;
  logic            full0_r;
  logic            full1_r;
  logic [XLEN-1:0] data0_r;
  logic [XLEN-1:0] data1_r;

  logic            elig0_s;
  logic            elig1_s;
  logic            grant0_s;
  logic            grant1_s;
  logic            grant_any_s;
  logic            grant_id_s;
  logic            wr0_s;
  logic            wr1_s;
  alu_req_t        issue_s;
  logic [XLEN-1:0] alu_out_s;

  // Eligibility and grant: a port blocked by its own in-flight op or by a full,
  // non-draining slot cannot win; ties go to the port not served last (RR) or port 0.
  always_comb begin
    elig0_s  = !rst && req0_valid && !(inflight_v_r && (inflight_id_r == PORT0))
               && !(full0_r && !resp0_ready);
    elig1_s  = !rst && req1_valid && !(inflight_v_r && (inflight_id_r == PORT1))
               && !(full1_r && !resp1_ready);
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (elig0_s && elig1_s) begin
      if (RR_ENABLE && (last_r == PORT0)) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b1;
      end
    end else begin
      grant0_s = elig0_s;
      grant1_s = elig1_s;
    end
    grant_any_s = grant0_s || grant1_s;
    grant_id_s  = grant1_s ? PORT1 : PORT0;
  end

  // Issue mux: the granted request drives the ALU; idle cycles issue a harmless 0+0.
  always_comb begin
    issue_s = '{op: ALU_OP_ADD, a: {XLEN{1'b0}}, b: {XLEN{1'b0}}};
    case ({grant1_s, grant0_s})
      2'b01:   issue_s = '{op: req0_op, a: req0_a, b: req0_b};
      2'b10:   issue_s = '{op: req1_op, a: req1_a, b: req1_b};
      default: issue_s = '{op: ALU_OP_ADD, a: {XLEN{1'b0}}, b: {XLEN{1'b0}}};
    endcase
  end

  alu u_alu (
    .clk   (clk),
    .rst   (rst),
    .op    (issue_s.op),
    .a     (issue_s.a),
    .b     (issue_s.b),
    .out_s (alu_out_s)
  );

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign wr0_s      = inflight_v_r && (inflight_id_r == PORT0);
  assign wr1_s      = inflight_v_r && (inflight_id_r == PORT1);

  // In-flight tag and round-robin pointer; reset drops any op already in the ALU.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_v_r  <= 1'b0;
      inflight_id_r <= PORT0;
      last_r        <= PORT1;
    end else begin
      inflight_v_r <= grant_any_s;
      if (grant_any_s) begin
        inflight_id_r <= grant_id_s;
        last_r        <= grant_id_s;
      end
    end
  end

  // Port 0 result slot: a capture wins over a same-cycle drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      full0_r <= 1'b0;
      data0_r <= {XLEN{1'b0}};
    end else if (wr0_s) begin
      full0_r <= 1'b1;
      data0_r <= alu_out_s;
    end else if (resp0_ready) begin
      full0_r <= 1'b0;
    end
  end

  // Port 1 result slot: a capture wins over a same-cycle drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      full1_r <= 1'b0;
      data1_r <= {XLEN{1'b0}};
    end else if (wr1_s) begin
      full1_r <= 1'b1;
      data1_r <= alu_out_s;
    end else if (resp1_ready) begin
      full1_r <= 1'b0;
    end
  end

  assign resp0_valid = full0_r;
  assign resp0_data  = data0_r;
  assign resp1_valid = full1_r;
  assign resp1_data  = data1_r;

endmodule
